// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/EX/MEM hazard inputs towards the controller,
// pipeline-register enables, flushes and status back to the core.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_idRs1;
  logic [4:0]       i_idRs2;
  logic             i_exMemRead;
  logic [4:0]       i_exRd;
  logic             i_memRedirect;
  logic             i_dmemReq;
  logic             i_dmemReady;

  logic             o_pcWrite;
  logic             o_pcSel;
  logic             o_ifidWrite;
  logic             o_ifidFlush;
  logic             o_idexWrite;
  logic             o_idexFlush;
  logic             o_exmemWrite;
  logic             o_exmemFlush;
  logic             o_memwbBubble;
  logic             o_memTimeout;
  logic [CNT_W-1:0] o_stallCnt;
  logic [CNT_W-1:0] o_flushCnt;

  modport master (
    output i_idRs1, i_idRs2, i_exMemRead, i_exRd, i_memRedirect, i_dmemReq, i_dmemReady,
    input  o_pcWrite, o_pcSel, o_ifidWrite, o_ifidFlush, o_idexWrite, o_idexFlush,
           o_exmemWrite, o_exmemFlush, o_memwbBubble, o_memTimeout, o_stallCnt, o_flushCnt
  );

  modport slave (
    input  i_idRs1, i_idRs2, i_exMemRead, i_exRd, i_memRedirect, i_dmemReq, i_dmemReady,
    output o_pcWrite, o_pcSel, o_ifidWrite, o_ifidFlush, o_idexWrite, o_idexFlush,
           o_exmemWrite, o_exmemFlush, o_memwbBubble, o_memTimeout, o_stallCnt, o_flushCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage RV32I pipeline: boot hold, memory-wait stall,
// MEM redirect flush, load-use interlock, wait watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MAX_WAIT    = 16,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    boot_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_cnt_inc;
  logic             timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic mem_wait;
  logic load_use;
  logic redirect_eff;
  logic stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WW-1:0] sat_inc_wait(input logic [WW-1:0] v);
    return (v == WW'(MAX_WAIT)) ? v : v + WW'(1);
  endfunction

  // Hazard qualification; only meaningful once the pipeline is running
  always_comb begin
    mem_wait     = (state == RUN) && bus.i_dmemReq && !bus.i_dmemReady;
    load_use     = bus.i_exMemRead && (bus.i_exRd != 5'd0) &&
                   ((bus.i_exRd == bus.i_idRs1) || (bus.i_exRd == bus.i_idRs2));
    redirect_eff = (state == RUN) && !mem_wait && bus.i_memRedirect;
    // A redirect squashes the dependent instruction, so its load-use is not a stall
    stall_evt    = mem_wait || ((state == RUN) && !bus.i_memRedirect && load_use);
    wait_cnt_inc = sat_inc_wait(wait_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if ((state == BOOT) && (boot_cnt == '0)) state_nxt = RUN;
  end

  always_comb begin
    bus.o_pcWrite     = 1'b1;
    bus.o_pcSel       = 1'b0;
    bus.o_ifidWrite   = 1'b1;
    bus.o_ifidFlush   = 1'b0;
    bus.o_idexWrite   = 1'b1;
    bus.o_idexFlush   = 1'b0;
    bus.o_exmemWrite  = 1'b1;
    bus.o_exmemFlush  = 1'b0;
    bus.o_memwbBubble = 1'b0;
    if (state == BOOT) begin
      bus.o_pcWrite     = 1'b0;
      bus.o_ifidWrite   = 1'b0;
      bus.o_ifidFlush   = 1'b1;
      bus.o_idexFlush   = 1'b1;
      bus.o_exmemFlush  = 1'b1;
      bus.o_memwbBubble = 1'b1;
    end else if (mem_wait) begin
      bus.o_pcWrite     = 1'b0;
      bus.o_ifidWrite   = 1'b0;
      bus.o_idexWrite   = 1'b0;
      bus.o_exmemWrite  = 1'b0;
      bus.o_memwbBubble = 1'b1;
    end else if (bus.i_memRedirect) begin
      bus.o_pcSel       = 1'b1;
      bus.o_ifidFlush   = 1'b1;
      bus.o_idexFlush   = 1'b1;
      bus.o_exmemFlush  = 1'b1;
    end else if (load_use) begin
      bus.o_pcWrite     = 1'b0;
      bus.o_ifidWrite   = 1'b0;
      bus.o_idexFlush   = 1'b1;
    end
  end

  // Boot countdown, wait watchdog and perf counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      boot_cnt  <= BW'(BOOT_CYCLES - 1);
      wait_cnt  <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state == BOOT) && (boot_cnt != '0)) boot_cnt <= boot_cnt - BW'(1);
      wait_cnt <= mem_wait ? wait_cnt_inc : '0;
      if (mem_wait && (wait_cnt_inc == WW'(MAX_WAIT))) timeout <= 1'b1;
      if (stall_evt)    stall_cnt <= sat_inc_cnt(stall_cnt);
      if (redirect_eff) flush_cnt <= sat_inc_cnt(flush_cnt);
    end
  end

  assign bus.o_memTimeout = timeout;
  assign bus.o_stallCnt   = stall_cnt;
  assign bus.o_flushCnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-level rule model.
module tb_pipe_hazard_ctrl;

  localparam int BOOT_CYCLES = 4;
  localparam int MAX_WAIT    = 16;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES),
    .MAX_WAIT   (MAX_WAIT),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: cycles of boot hold left, current wait run length, counters
  int m_boot  = 0;
  int m_wait  = 0;
  bit m_to    = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit mr, input logic [4:0] rd, input bit rdr,
                      input bit rq, input bit rdy);
    logic [8:0] exp_ctl, got_ctl;
    bit run, mw, lu;
    @(negedge clk);
    rst               = r;
    bus.i_idRs1       = rs1;
    bus.i_idRs2       = rs2;
    bus.i_exMemRead   = mr;
    bus.i_exRd        = rd;
    bus.i_memRedirect = rdr;
    bus.i_dmemReq     = rq;
    bus.i_dmemReady   = rdy;
    #1;
    run = (m_boot == 0);
    mw  = rq && !rdy;
    lu  = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    // {pcWrite, pcSel, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite, exmemFlush, bubble}
    if (!run)      exp_ctl = 9'b000111111;
    else if (mw)   exp_ctl = 9'b000000001;
    else if (rdr)  exp_ctl = 9'b111111110;
    else if (lu)   exp_ctl = 9'b000011100;
    else           exp_ctl = 9'b101010100;
    got_ctl = {bus.o_pcWrite, bus.o_pcSel, bus.o_ifidWrite, bus.o_ifidFlush,
               bus.o_idexWrite, bus.o_idexFlush, bus.o_exmemWrite, bus.o_exmemFlush,
               bus.o_memwbBubble};
    if (m_valid) begin
      chk("ctl", 32'(got_ctl), 32'(exp_ctl));
      chk("stallCnt", 32'(bus.o_stallCnt), 32'(m_stall));
      chk("flushCnt", 32'(bus.o_flushCnt), 32'(m_flush));
      chk("memTimeout", 32'(bus.o_memTimeout), 32'(m_to));
    end
    @(posedge clk);
    if (r) begin
      m_boot  = BOOT_CYCLES;
      m_wait  = 0;
      m_to    = 1'b0;
      m_stall = 0;
      m_flush = 0;
      m_valid = 1'b1;
    end else if (!run) begin
      m_boot--;
    end else begin
      if (mw) begin
        if (m_wait < MAX_WAIT) m_wait++;
        if (m_wait == MAX_WAIT) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
      if ((mw || (lu && !rdr)) && m_stall < CNT_MAX) m_stall++;
      if (!mw && rdr && m_flush < CNT_MAX) m_flush++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_idRs1 = '0; bus.i_idRs2 = '0; bus.i_exMemRead = 1'b0; bus.i_exRd = '0;
    bus.i_memRedirect = 1'b0; bus.i_dmemReq = 1'b0; bus.i_dmemReady = 1'b0;

    // Reset, boot hold, then idle run
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    idle(BOOT_CYCLES + 2);

    // Load-use on rs2, then x0 destination must not stall
    step(0, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0);
    step(0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
    // Redirect with simultaneous load-use
    step(0, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0);
    idle(1);
    // Three wait cycles with redirect pending, honoured when ready
    for (int i = 0; i < 3; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1);
    // Long wait trips the watchdog, which stays set afterwards
    for (int i = 0; i < 20; i++) step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    idle(3);
    // Twenty load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 5'd3, 5'd0, 1, 5'd3, 0, 0, 0);
    // Reset in the middle of a stall
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
    idle(BOOT_CYCLES + 1);

    // Randomized traffic with occasional resets and ready-starved bursts
    for (int i = 0; i < 3000; i++) begin
      bit starve;
      starve = ((i / 200) % 3) == 2;
      step(($urandom_range(0, 299) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 1) == 0),
           starve ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
